// File: rtl/adder_tree_pipe_pkg.sv
// rtl/adder_tree_pipe_pkg.sv - shared constants, helpers and sideband type for the adder tree
package adder_tree_pipe_pkg;

  // Width of one PE-array lane slice on the output bus.
  localparam int LANE_BITS = 16;

  // Lane count of the PE reduction path this block replaces.
  localparam int DEFAULT_NUM_IN = 16;

  // Ceiling log2 usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Number of registered adder levels for the default lane count.
  localparam int TREE_DEPTH = clog2(DEFAULT_NUM_IN);

  // Lane offset of tree level `level` inside a flat vector holding all levels
  // back to back: level 0 has num_in lanes, level 1 num_in/2, and so on.
  function automatic int level_offset(input int num_in, input int level);
    return 2 * num_in - 2 * (num_in >> level);
  endfunction

  // Sideband that travels alongside each partial-sum level.
  typedef struct packed {
    logic valid;
    logic acc_mode;
    logic acc_last;
  } side_t;

endpackage

// File: rtl/adder_tree_pipe_if.sv
// rtl/adder_tree_pipe_if.sv - beat input and result output handshake bundle
interface adder_tree_pipe_if #(
  parameter int DATA_BITWIDTH = 16,
  parameter int NUM_IN        = 16
);

  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_IN*DATA_BITWIDTH-1:0] in_data;
  logic [NUM_IN-1:0]               in_mask;
  logic                            acc_mode;
  logic                            acc_last;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_BITWIDTH-1:0]        out_data;

  // Producer of beats and consumer of results.
  modport master (
    output in_valid, in_data, in_mask, acc_mode, acc_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The adder tree itself.
  modport slave (
    input  in_valid, in_data, in_mask, acc_mode, acc_last, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/adder_tree_stage.sv
// rtl/adder_tree_stage.sv - one registered level of pairwise adds with sideband
module adder_tree_stage
  import adder_tree_pipe_pkg::*;
#(
  parameter int DATA_BITWIDTH = LANE_BITS,
  parameter int LANES_IN      = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    en_i,
  input  side_t                                   side_i,
  input  logic [LANES_IN*DATA_BITWIDTH-1:0]       data_i,
  output side_t                                   side_o,
  output logic [(LANES_IN/2)*DATA_BITWIDTH-1:0]   data_o
);

  localparam int W        = DATA_BITWIDTH;
  localparam int LANES_OUT = LANES_IN / 2;

  logic [LANES_OUT*W-1:0] data_d;
  logic [LANES_OUT*W-1:0] data_q;
  side_t                  side_q;

  // Pairwise sums of neighbouring lanes, truncated to the lane width.
  always_comb begin
    data_d = '0;
    for (int i = 0; i < LANES_OUT; i++) begin
      data_d[i*W +: W] = data_i[(2*i)*W +: W] + data_i[(2*i+1)*W +: W];
    end
  end

  // Level register; bubbles load too so the whole level moves as one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      side_q <= '0;
    end else if (en_i) begin
      data_q <= data_d;
      side_q <= side_i;
    end
  end

  assign data_o = data_q;
  assign side_o = side_q;

endmodule

// File: rtl/adder_tree_pipe.sv
// rtl/adder_tree_pipe.sv - pipelined masked adder tree with multi-beat accumulate
module adder_tree_pipe
  import adder_tree_pipe_pkg::*;
#(
  parameter int DATA_BITWIDTH = LANE_BITS,
  parameter int NUM_IN        = DEFAULT_NUM_IN
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_tree_pipe_if.slave   bus_io
);

  localparam int W = DATA_BITWIDTH;
  localparam int D = clog2(NUM_IN);

  // All tree levels packed back to back: level 0 is the masked input,
  // level D is the single final sum.
  wire  [(2*NUM_IN-1)*W-1:0] tree_w;
  side_t                     side_w [D+1];

  logic [NUM_IN*W-1:0] lane0_w;
  logic                adv;
  logic [W-1:0]        tree_sum;
  side_t               side_fin;
  logic [W-1:0]        acc_sum;

  logic [W-1:0] acc_d, acc_q;
  logic [W-1:0] out_data_d, out_data_q;
  logic         out_valid_d, out_valid_q;

  // A held result stalls every register in the pipe, bubbles included.
  assign adv             = !out_valid_q || bus_io.out_ready;
  assign bus_io.in_ready = adv;

  // Masked lanes enter the tree as zero.
  always_comb begin
    lane0_w = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus_io.in_mask[i]) lane0_w[i*W +: W] = bus_io.in_data[i*W +: W];
    end
  end

  assign tree_w[NUM_IN*W-1:0] = lane0_w;

  // Stage registers only load on adv, so in_valid alone marks an accepted beat.
  assign side_w[0] = '{valid: bus_io.in_valid,
                       acc_mode: bus_io.acc_mode,
                       acc_last: bus_io.acc_last};

  for (genvar k = 0; k < D; k++) begin : g_stage
    localparam int LIN = NUM_IN >> k;
    adder_tree_stage #(
      .DATA_BITWIDTH (W),
      .LANES_IN      (LIN)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (adv),
      .side_i (side_w[k]),
      .data_i (tree_w[level_offset(NUM_IN, k)*W +: LIN*W]),
      .side_o (side_w[k+1]),
      .data_o (tree_w[level_offset(NUM_IN, k+1)*W +: (LIN/2)*W])
    );
  end

  assign tree_sum = tree_w[level_offset(NUM_IN, D)*W +: W];
  assign side_fin = side_w[D];
  assign acc_sum  = acc_q + tree_sum;

  // Output stage: plain beats bypass the accumulator, group beats fold into it
  // and the closing beat emits the group total and clears it.
  always_comb begin
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (adv) begin
      out_valid_d = 1'b0;
      if (side_fin.valid) begin
        if (!side_fin.acc_mode) begin
          out_data_d  = tree_sum;
          out_valid_d = 1'b1;
        end else if (!side_fin.acc_last) begin
          acc_d = acc_sum;
        end else begin
          out_data_d  = acc_sum;
          acc_d       = '0;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  // Accumulator and result registers; reset discards any open group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// tb/tb_adder_tree_pipe.sv - self-checking bench for adder_tree_pipe
module tb_adder_tree_pipe;

  localparam int W = 16;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_tree_pipe_if #(.DATA_BITWIDTH(W), .NUM_IN(N)) bus ();

  adder_tree_pipe #(.DATA_BITWIDTH(W), .NUM_IN(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] got_q [$];
  logic [W-1:0] macc;
  logic [W-1:0] ln [N];
  logic         prev_stall;
  logic [W-1:0] prev_data;
  logic         last_valid;
  logic         accepted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack_lanes();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = ln[i];
    return d;
  endfunction

  task automatic fill(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) ln[i] = v;
  endtask

  task automatic model_accept();
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.in_mask[i]) s = s + bus.in_data[i*W +: W];
    end
    if (!bus.acc_mode) begin
      exp_q.push_back(s);
    end else if (!bus.acc_last) begin
      macc = macc + s;
    end else begin
      exp_q.push_back(macc + s);
      macc = '0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    got_q.delete();
    macc       = '0;
    prev_stall = 1'b0;
  endtask

  task automatic tick();
    accepted = 1'b0;
    @(negedge clk);
    if (prev_stall) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, prev_data);
    end
    if (bus.out_valid && !bus.out_ready) check("stall_in_ready", bus.in_ready, 0);
    if (bus.in_valid && bus.in_ready) begin
      model_accept();
      accepted = 1'b1;
    end
    if (bus.out_valid && bus.out_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL spurious_out observed=%0h expected=none", bus.out_data);
      end
      if (exp_q.size() != 0) check("scoreboard", bus.out_data, exp_q.pop_front());
      got_q.push_back(bus.out_data);
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    last_valid = bus.out_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] m, input logic am, input logic al);
    bus.in_data  = pack_lanes();
    bus.in_mask  = m;
    bus.acc_mode = am;
    bus.acc_last = al;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (accepted) break;
    end
    check("accept", accepted, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_one(input string tag, input logic [W-1:0] value);
    for (int t = 0; t < 20; t++) begin
      if (got_q.size() > 0) break;
      tick();
    end
    check({tag, "_count"}, got_q.size(), 1);
    if (got_q.size() > 0) check(tag, got_q.pop_front(), value);
    got_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n;
    int b;
    int cyc;
    logic need_new;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mask   = '0;
    bus.acc_mode  = 1'b0;
    bus.acc_last  = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();
    last_valid = 1'b0;
    accepted   = 1'b0;
    prev_data  = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    // all ones: value, latency and single-cycle valid
    fill(16'd1);
    send(16'hFFFF, 1'b0, 1'b0);
    n = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      n++;
      if (last_valid) break;
    end
    check("latency", n, 5);
    tick();
    check("one_cycle_valid", last_valid, 0);
    expect_one("all_ones", 16'd16);

    // wrap-around
    fill(16'h1000);
    send(16'hFFFF, 1'b0, 1'b0);
    expect_one("wrap_1000", 16'h0000);
    for (int i = 0; i < N; i++) ln[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0001;
    send(16'hFFFF, 1'b0, 1'b0);
    expect_one("wrap_alt", 16'h0000);

    // masking with lane i = i
    for (int i = 0; i < N; i++) ln[i] = 16'(i);
    send(16'h00FF, 1'b0, 1'b0);
    expect_one("mask_00ff", 16'd28);
    send(16'h8001, 1'b0, 1'b0);
    expect_one("mask_8001", 16'd15);
    send(16'h0000, 1'b0, 1'b1);
    expect_one("mask_0000", 16'd0);

    // three-beat accumulation group, then a plain beat
    fill(16'd1);
    send(16'hFFFF, 1'b1, 1'b0);
    fill(16'd2);
    send(16'hFFFF, 1'b1, 1'b0);
    fill(16'd3);
    send(16'hFFFF, 1'b1, 1'b1);
    repeat (10) tick();
    expect_one("acc_group", 16'd96);
    fill(16'd1);
    send(16'hFFFF, 1'b0, 1'b0);
    expect_one("after_group", 16'd16);

    // back-to-back stream with a three-cycle output stall
    got_q.delete();
    b = 0;
    cyc = 0;
    need_new = 1'b1;
    while (b < 8 && cyc < 100) begin
      if (need_new) begin
        for (int i = 0; i < N; i++) ln[i] = 16'($urandom);
        bus.in_data = pack_lanes();
      end
      bus.in_mask   = 16'hFFFF;
      bus.acc_mode  = 1'b0;
      bus.acc_last  = 1'b0;
      bus.in_valid  = 1'b1;
      bus.out_ready = !(cyc >= 6 && cyc < 9);
      tick();
      need_new = accepted;
      if (accepted) b++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (15) tick();
    check("stream_count", got_q.size(), 8);
    got_q.delete();

    // randomized traffic with random backpressure
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < N; i++) ln[i] = 16'($urandom);
      bus.in_data   = pack_lanes();
      bus.in_mask   = 16'($urandom);
      bus.acc_mode  = 1'($urandom);
      bus.acc_last  = 1'($urandom);
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(3) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    fill(16'd7);
    send(16'hFFFF, 1'b1, 1'b1);
    repeat (15) tick();
    check("random_drained", exp_q.size(), 0);
    got_q.delete();

    // open group plus a stalled result, then asynchronous reset
    fill(16'd1);
    send(16'hFFFF, 1'b1, 1'b0);
    fill(16'd2);
    send(16'hFFFF, 1'b1, 1'b0);
    repeat (8) tick();
    check("open_group_silent", got_q.size(), 0);
    fill(16'd1);
    bus.out_ready = 1'b0;
    send(16'hFFFF, 1'b0, 1'b0);
    repeat (8) tick();
    check("stalled_valid", last_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_ready", bus.in_ready, 1);
    model_reset();
    #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    fill(16'd1);
    send(16'hFFFF, 1'b1, 1'b1);
    expect_one("post_reset_group", 16'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
